// File: rtl/unpool_upsample_stream_if.sv
// Handshake bundle for unpool_upsample_stream: input pixel stream and
// upsampled output stream with regenerated coordinates.
interface unpool_upsample_stream_if #(
  parameter int unsigned IN_WIDTH   = 320,
  parameter int unsigned IN_HEIGHT  = 240,
  parameter int unsigned FIXED_BITW = 16,
  parameter int unsigned UNITS      = 8,
  parameter int unsigned SCALE      = 2
);
  localparam int unsigned PIX_W  = FIXED_BITW * UNITS;
  localparam int unsigned H_BITW = $clog2(IN_WIDTH);
  localparam int unsigned V_BITW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned S_BITW = $clog2(SCALE);

  logic                       in_valid;
  logic                       in_ready;
  logic                       in_sof;
  logic [PIX_W-1:0]           in_pixels;
  logic                       out_valid;
  logic                       out_ready;
  logic [PIX_W-1:0]           out_pixels;
  logic [V_BITW+S_BITW-1:0]   out_vcnt;
  logic [H_BITW+S_BITW-1:0]   out_hcnt;
  logic                       out_eof;

  // Producer of input pixels / consumer of output pixels
  modport master (
    output in_valid, in_sof, in_pixels, out_ready,
    input  in_ready, out_valid, out_pixels, out_vcnt, out_hcnt, out_eof
  );

  // The unpooling stage itself
  modport slave (
    input  in_valid, in_sof, in_pixels, out_ready,
    output in_ready, out_valid, out_pixels, out_vcnt, out_hcnt, out_eof
  );
endinterface

// File: rtl/unpool_upsample_stream.sv
// Streaming nearest-neighbour unpooling: each input line is captured into one
// of two line buffers and replayed SCALE times, each pixel SCALE times wide.
// Optional macro UNPOOL_ZERO_FILL_EN: only the top-left position of every
// SCALE x SCALE block carries the stored pixel, the rest are zero.
module unpool_upsample_stream #(
  parameter int unsigned IN_WIDTH   = 320,
  parameter int unsigned IN_HEIGHT  = 240,
  parameter int unsigned FIXED_BITW = 16,
  parameter int unsigned UNITS      = 8,
  parameter int unsigned SCALE      = 2
) (
  input  logic                  clock,
  input  logic                  n_rst,
  unpool_upsample_stream_if.slave bus
);
  localparam int unsigned PIX_W  = FIXED_BITW * UNITS;
  localparam int unsigned H_BITW = $clog2(IN_WIDTH);
  localparam int unsigned V_BITW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned S_BITW = $clog2(SCALE);

  localparam logic [H_BITW-1:0] COL_LAST = H_BITW'(IN_WIDTH - 1);
  localparam logic [V_BITW-1:0] ROW_LAST = V_BITW'(IN_HEIGHT - 1);
  localparam logic [S_BITW-1:0] SUB_LAST = S_BITW'(SCALE - 1);

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  logic [PIX_W-1:0]  line_buf [2][IN_WIDTH];
  logic [V_BITW-1:0] line_row [2];
  logic [1:0]        full;
  logic              wr_sel, rd_sel;
  logic [H_BITW-1:0] wr_col, rd_col;
  logic [V_BITW-1:0] wr_row;
  logic [S_BITW-1:0] sub_col, sub_row;
  logic              in_ready_q;

  logic                     out_valid_q;
  logic [PIX_W-1:0]         out_pixels_q;
  logic [V_BITW+S_BITW-1:0] out_vcnt_q;
  logic [H_BITW+S_BITW-1:0] out_hcnt_q;
  logic                     out_eof_q;

  logic              accept_c, wr_last_c, emit_c, load_c, rd_last_c;
  logic [H_BITW-1:0] wr_col_eff_c;
  logic [V_BITW-1:0] wr_row_eff_c;
  logic [1:0]        set_full_c, clr_full_c, full_next_c;
  logic              wr_sel_next_c, rd_sel_next_c;
  logic [PIX_W-1:0]  rd_pix_c;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pixels = out_pixels_q;
  assign bus.out_vcnt   = out_vcnt_q;
  assign bus.out_hcnt   = out_hcnt_q;
  assign bus.out_eof    = out_eof_q;

  // Handshake decode, buffer full-flag update and replay pixel selection
  always_comb begin
    accept_c      = bus.in_valid && in_ready_q;
    wr_col_eff_c  = bus.in_sof ? '0 : wr_col;
    wr_row_eff_c  = bus.in_sof ? '0 : wr_row;
    wr_last_c     = accept_c && (wr_col_eff_c == COL_LAST);
    emit_c        = (state == EMIT) || full[rd_sel];
    load_c        = emit_c && (!out_valid_q || bus.out_ready);
    rd_last_c     = load_c && (sub_row == SUB_LAST) && (rd_col == COL_LAST)
                    && (sub_col == SUB_LAST);
    set_full_c    = '0;
    clr_full_c    = '0;
    if (wr_last_c) set_full_c[wr_sel] = 1'b1;
    if (rd_last_c) clr_full_c[rd_sel] = 1'b1;
    full_next_c   = (full | set_full_c) & ~clr_full_c;
    wr_sel_next_c = wr_sel ^ wr_last_c;
    rd_sel_next_c = rd_sel ^ rd_last_c;
    rd_pix_c      = line_buf[rd_sel][rd_col];
`ifdef UNPOOL_ZERO_FILL_EN
    if ((sub_row != '0) || (sub_col != '0)) rd_pix_c = '0;
`endif
  end

  // Line buffer storage; contents need no reset since full flags gate reads
  always_ff @(posedge clock) begin
    if (accept_c) line_buf[wr_sel][wr_col_eff_c] <= bus.in_pixels;
  end

  // Write-side counters, full flags and registered in_ready
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      full        <= '0;
      wr_sel      <= 1'b0;
      wr_col      <= '0;
      wr_row      <= '0;
      line_row[0] <= '0;
      line_row[1] <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      full       <= full_next_c;
      wr_sel     <= wr_sel_next_c;
      in_ready_q <= !full_next_c[wr_sel_next_c];
      if (accept_c) begin
        if (wr_last_c) begin
          wr_col           <= '0;
          line_row[wr_sel] <= wr_row_eff_c;
          wr_row           <= (wr_row_eff_c == ROW_LAST) ? '0 : wr_row_eff_c + V_BITW'(1);
        end else begin
          wr_col <= wr_col_eff_c + H_BITW'(1);
          wr_row <= wr_row_eff_c;
        end
      end
    end
  end

  // Read FSM: replays the current buffer SCALE x SCALE into the output register
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      rd_sel       <= 1'b0;
      rd_col       <= '0;
      sub_col      <= '0;
      sub_row      <= '0;
      out_valid_q  <= 1'b0;
      out_pixels_q <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
      out_eof_q    <= 1'b0;
    end else begin
      rd_sel <= rd_sel_next_c;
      if (load_c) begin
        out_valid_q  <= 1'b1;
        out_pixels_q <= rd_pix_c;
        out_vcnt_q   <= {line_row[rd_sel], sub_row};
        out_hcnt_q   <= {rd_col, sub_col};
        out_eof_q    <= rd_last_c && (line_row[rd_sel] == ROW_LAST);
        if (sub_col != SUB_LAST) begin
          sub_col <= sub_col + S_BITW'(1);
        end else begin
          sub_col <= '0;
          if (rd_col != COL_LAST) begin
            rd_col <= rd_col + H_BITW'(1);
          end else begin
            rd_col  <= '0;
            sub_row <= (sub_row == SUB_LAST) ? '0 : sub_row + S_BITW'(1);
          end
        end
        if (rd_last_c) state <= full_next_c[rd_sel_next_c] ? EMIT : IDLE;
        else           state <= EMIT;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_unpool_upsample_stream.sv
// Directed bench for unpool_upsample_stream: SCALE=2 4x2 instance and a
// SCALE=4 2x1 instance, checked against hand-written expected streams.
module tb_unpool_upsample_stream;
  logic clock = 1'b0;
  logic n_rst;
  always #5 clock = ~clock;

  unpool_upsample_stream_if #(.IN_WIDTH(4), .IN_HEIGHT(2), .FIXED_BITW(8), .UNITS(1), .SCALE(2)) bus2 ();
  unpool_upsample_stream_if #(.IN_WIDTH(2), .IN_HEIGHT(1), .FIXED_BITW(8), .UNITS(1), .SCALE(4)) bus4 ();

  unpool_upsample_stream #(.IN_WIDTH(4), .IN_HEIGHT(2), .FIXED_BITW(8), .UNITS(1), .SCALE(2)) u_dut2 (
    .clock(clock), .n_rst(n_rst), .bus(bus2));
  unpool_upsample_stream #(.IN_WIDTH(2), .IN_HEIGHT(1), .FIXED_BITW(8), .UNITS(1), .SCALE(4)) u_dut4 (
    .clock(clock), .n_rst(n_rst), .bus(bus4));

`ifdef UNPOOL_ZERO_FILL_EN
  localparam int EXP_T1 [32] = '{1,0,2,0,3,0,4,0, 0,0,0,0,0,0,0,0,
                                 5,0,6,0,7,0,8,0, 0,0,0,0,0,0,0,0};
`else
  localparam int EXP_T1 [32] = '{1,1,2,2,3,3,4,4, 1,1,2,2,3,3,4,4,
                                 5,5,6,6,7,7,8,8, 5,5,6,6,7,7,8,8};
`endif
  localparam int PIX_A = 165;
  localparam int PIX_B = 60;

  int n_checks = 0;
  int n_pass   = 0;
  int stim [$];
  int got_pix [64];
  int got_v   [64];
  int got_h   [64];
  int got_eof [64];
  int got_cyc [64];
  bit saw_stall;
  bit saw_valid;

  // Single comparison point: counts and reports
  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive stim[0..n-1] with sof on the first beat; call just after a negedge
  task automatic feed(input bit sel, input int n);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 4000) begin
      if (sel) begin
        bus4.in_valid = 1'b1; bus4.in_pixels = 8'(stim[i]); bus4.in_sof = (i == 0); acc = bus4.in_ready;
      end else begin
        bus2.in_valid = 1'b1; bus2.in_pixels = 8'(stim[i]); bus2.in_sof = (i == 0); acc = bus2.in_ready;
      end
      if (!acc) saw_stall = 1'b1;
      @(negedge clock);
      guard++;
      if (acc) i++;
    end
    bus2.in_valid = 1'b0; bus2.in_sof = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_sof = 1'b0;
    check_eq("feed_done", i, n);
  endtask

  // Collect n output beats; optional stalls with hold checks
  task automatic collect(input bit sel, input int n, input bit toggle);
    int k = 0;
    int guard = 0;
    bit v, rdy, pend;
    int pix, vc, hc, eo, held;
    bit [3:0] pat = 4'b1001;
    pend = 1'b0;
    held = 0;
    while (k < n && guard < 4000) begin
      if (sel) begin
        v = bus4.out_valid; pix = 32'(bus4.out_pixels); vc = 32'(bus4.out_vcnt);
        hc = 32'(bus4.out_hcnt); eo = 32'(bus4.out_eof);
      end else begin
        v = bus2.out_valid; pix = 32'(bus2.out_pixels); vc = 32'(bus2.out_vcnt);
        hc = 32'(bus2.out_hcnt); eo = 32'(bus2.out_eof);
      end
      if (pend) begin
        check_eq("hold_valid", 32'(v), 1);
        check_eq("hold_data", (pix << 16) | (vc << 8) | (hc << 4) | eo, held);
        pend = 1'b0;
      end
      rdy = toggle ? pat[2'($urandom_range(3, 0))] : 1'b1;
      if (sel) bus4.out_ready = rdy; else bus2.out_ready = rdy;
      if (v && rdy) begin
        got_pix[k] = pix; got_v[k] = vc; got_h[k] = hc; got_eof[k] = eo; got_cyc[k] = guard;
        k++;
      end else if (v) begin
        pend = 1'b1;
        held = (pix << 16) | (vc << 8) | (hc << 4) | eo;
      end
      @(negedge clock);
      guard++;
    end
    bus2.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    check_eq("beat_count", k, n);
  endtask

  // Compare collected beats lo..hi-1 of the SCALE=2 instance; add offsets frame 2 values
  task automatic check_beats2(input string tag, input int lo, input int hi, input int add);
    int j;
    for (int b = lo; b < hi; b++) begin
      j = b % 32;
      check_eq($sformatf("%s_pix%0d", tag, b), got_pix[b], (EXP_T1[j] == 0) ? 0 : EXP_T1[j] + add);
      check_eq($sformatf("%s_v%0d", tag, b), got_v[b], j / 8);
      check_eq($sformatf("%s_h%0d", tag, b), got_h[b], j % 8);
      check_eq($sformatf("%s_eof%0d", tag, b), got_eof[b], (j == 31) ? 1 : 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(bus2.in_ready), 0);
    check_eq({tag, "_out_valid"}, 32'(bus2.out_valid), 0);
    check_eq({tag, "_out_pixels"}, 32'(bus2.out_pixels), 0);
    check_eq({tag, "_out_vcnt"}, 32'(bus2.out_vcnt), 0);
    check_eq({tag, "_out_hcnt"}, 32'(bus2.out_hcnt), 0);
    check_eq({tag, "_out_eof"}, 32'(bus2.out_eof), 0);
  endtask

  initial begin
    int expv, h, v;
    n_rst = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_sof = 1'b0; bus2.in_pixels = '0; bus2.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_sof = 1'b0; bus4.in_pixels = '0; bus4.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    n_rst = 1'b1;
    @(negedge clock);
    check_eq("ready_after_reset", 32'(bus2.in_ready), 1);
    check_eq("ready4_after_reset", 32'(bus4.in_ready), 1);

    // Basic frame, always-ready sink
    stim = '{1, 2, 3, 4, 5, 6, 7, 8};
    fork feed(1'b0, 8); collect(1'b0, 32, 1'b0); join
    check_beats2("t1", 0, 32, 0);

    // Two back-to-back frames: writer must stall, reader must not bubble
    stim = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    saw_stall = 1'b0;
    fork feed(1'b0, 16); collect(1'b0, 64, 1'b0); join
    check_eq("t2_in_ready_dropped", 32'(saw_stall), 1);
    check_eq("t2_no_gap", got_cyc[63] - got_cyc[0], 63);
    check_beats2("t2a", 0, 32, 0);
    check_beats2("t2b", 32, 64, 8);

    // Back-pressured sink
    stim = '{1, 2, 3, 4, 5, 6, 7, 8};
    fork feed(1'b0, 8); collect(1'b0, 32, 1'b1); join
    check_beats2("t3", 0, 32, 0);

    // SCALE=4 instance, one line A,B
    stim = '{PIX_A, PIX_B};
    fork feed(1'b1, 2); collect(1'b1, 32, 1'b0); join
    for (int b = 0; b < 32; b++) begin
      h = b % 8;
      v = b / 8;
      expv = (h < 4) ? PIX_A : PIX_B;
`ifdef UNPOOL_ZERO_FILL_EN
      if (!(v == 0 && (h == 0 || h == 4))) expv = 0;
`endif
      check_eq($sformatf("t4_pix%0d", b), got_pix[b], expv);
      check_eq($sformatf("t4_v%0d", b), got_v[b], v);
      check_eq($sformatf("t4_h%0d", b), got_h[b], h);
      check_eq($sformatf("t4_eof%0d", b), got_eof[b], (b == 31) ? 1 : 0);
    end

    // Reset with a stalled output beat and a partial line in flight
    bus2.out_ready = 1'b0;
    stim = '{21, 22, 23, 24, 25, 26, 27};
    feed(1'b0, 7);
    check_eq("t5_stalled_valid", 32'(bus2.out_valid), 1);
    n_rst = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    @(negedge clock);
    check_outputs_zero("t5_reset_hold");
    n_rst = 1'b1;
    bus2.out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (bus2.out_valid) saw_valid = 1'b1;
    end
    check_eq("t5_no_stale_output", 32'(saw_valid), 0);
    stim = '{1, 2, 3, 4};
    fork feed(1'b0, 4); collect(1'b0, 16, 1'b0); join
    check_beats2("t5", 0, 16, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
